// File: rtl/aes_stream_loader.sv
// Word-stream front end for the AES-128 pipeline: packs 4 words into a block, issues it with the key and tracks cipher latency.
// Optional AES_LOADER_BYTESWAP_EN byte-reverses each stream word before packing.
module aes_stream_loader #(
  parameter int unsigned WORD    = 32,
  parameter int unsigned LENGTH  = 128,
  parameter int unsigned LATENCY = 12
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [WORD-1:0]   s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [LENGTH-1:0] key_in,
  input  logic              key_load,
  output logic              key_ready,
  output logic [LENGTH-1:0] usrText,
  output logic [LENGTH-1:0] Key,
  output logic              blk_issue,
  output logic              ct_valid,
  output logic [15:0]       blk_cnt
);

  typedef enum logic [1:0] {
    NOKEY   = 2'd0,
    COLLECT = 2'd1,
    ISSUE   = 2'd2
  } state_t;

  state_t              state;
  state_t              stateNext;
  logic [1:0]          wordCnt;
  logic [LATENCY-1:0]  latSr;

  function automatic logic [WORD-1:0] packWord(input logic [WORD-1:0] w);
    logic [WORD-1:0] r;
`ifdef AES_LOADER_BYTESWAP_EN
    r = '0;
    for (int unsigned b = 0; b < WORD / 8; b++) begin
      r[8*b +: 8] = w[WORD-1-8*b -: 8];
    end
`else
    r = w;
`endif
    return r;
  endfunction

  always_comb begin
    stateNext = state;
    s_ready   = 1'b0;
    key_ready = 1'b0;
    blk_issue = 1'b0;
    case (state)
      NOKEY: begin
        key_ready = 1'b1;
        if (key_load) stateNext = COLLECT;
      end
      COLLECT: begin
        key_ready = 1'b1;
        // key load takes priority over an offered word in the same cycle
        s_ready   = !key_load;
        if (!key_load && s_valid && wordCnt == 2'd3) stateNext = ISSUE;
      end
      ISSUE: begin
        blk_issue = 1'b1;
        stateNext = COLLECT;
      end
      default: stateNext = NOKEY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state   <= NOKEY;
      wordCnt <= '0;
      usrText <= '0;
      Key     <= '0;
      blk_cnt <= '0;
      latSr   <= '0;
    end else begin
      state <= stateNext;
      latSr <= {latSr[LATENCY-2:0], blk_issue};
      if (key_load && key_ready) begin
        Key     <= key_in;
        wordCnt <= '0;
      end else if (s_valid && s_ready) begin
        for (int unsigned k = 0; k < LENGTH / WORD; k++) begin
          if (wordCnt == 2'(k)) usrText[LENGTH-1-WORD*k -: WORD] <= packWord(s_data);
        end
        wordCnt <= 2'(wordCnt + 2'd1);
      end
      if (state == ISSUE) begin
        blk_cnt <= 16'(blk_cnt + 16'd1);
        wordCnt <= '0;
      end
    end
  end

  assign ct_valid = latSr[LATENCY-1];

endmodule

// File: tb/tb_aes_stream_loader.sv
// Directed bench for aes_stream_loader: FIPS-197 vector table plus multi-cycle corner sequences.
module tb_aes_stream_loader;

  logic         clk;
  logic         nrst;
  logic [31:0]  s_data;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] key_in;
  logic         key_load;
  logic         key_ready;
  logic [127:0] usrText;
  logic [127:0] Key;
  logic         blk_issue;
  logic         ct_valid;
  logic [15:0]  blk_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;

  aes_stream_loader #(.WORD(32), .LENGTH(128), .LATENCY(12)) dut (
    .clk(clk), .nrst(nrst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .key_in(key_in), .key_load(key_load), .key_ready(key_ready),
    .usrText(usrText), .Key(Key), .blk_issue(blk_issue), .ct_valid(ct_valid),
    .blk_cnt(blk_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         kl;
    logic [127:0] ki;
    logic         sv;
    logic [31:0]  sd;
    logic         eRdy;
    logic         eKrdy;
    logic         eIss;
    logic         eCt;
    logic [15:0]  eCnt;
    logic         chkData;
    logic [127:0] eText;
    logic [127:0] eKey;
  } vec_t;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2 = 128'hdeadbeef_01234567_89abcdef_cafef00d;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

  vec_t tbl [19];

  function automatic logic [31:0] bsw(input logic [31:0] w);
`ifdef AES_LOADER_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge; outputs are checked 1ns later.
  task automatic cyc(input logic rn, input logic kl, input logic [127:0] ki,
                     input logic sv, input logic [31:0] sd);
    @(negedge clk);
    nrst = rn; key_load = kl; key_in = ki; s_valid = sv; s_data = sd;
    #1;
  endtask

  task automatic doReset();
    cyc(1'b0, 1'b0, '0, 1'b0, '0);
    cyc(1'b1, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    logic [31:0] w [4];
    logic [31:0] wd;
    nrst = 1'b0; key_load = 1'b0; key_in = '0; s_valid = 1'b0; s_data = '0;

    // FIPS-197 C.1 vector table
    for (int i = 0; i < 4; i++) begin
      wd = PT[127-32*i -: 32];
      w[i] = bsw(wd);
    end
    for (int i = 0; i < 19; i++) begin
      tbl[i] = '{kl: 1'b0, ki: '0, sv: 1'b0, sd: '0, eRdy: 1'b1, eKrdy: 1'b1,
                 eIss: 1'b0, eCt: (i == 17), eCnt: (i >= 6) ? 16'd1 : 16'd0,
                 chkData: 1'b0, eText: '0, eKey: '0};
    end
    tbl[0].kl = 1'b1; tbl[0].ki = K1; tbl[0].eRdy = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tbl[i].sv = 1'b1; tbl[i].sd = w[i-1];
    end
    tbl[5].eRdy = 1'b0; tbl[5].eKrdy = 1'b0; tbl[5].eIss = 1'b1;
    tbl[5].chkData = 1'b1; tbl[5].eText = PT; tbl[5].eKey = K1;

    cyc(1'b0, 1'b0, '0, 1'b0, '0);
    cyc(1'b1, 1'b0, '0, 1'b0, '0);
    chk("rst_text", usrText, '0);
    chk("rst_key", Key, '0);
    chk("rst_cnt", {112'd0, blk_cnt}, '0);
    chk("rst_iss_ct", {126'd0, blk_issue, ct_valid}, '0);

    for (int i = 0; i < 19; i++) begin
      cyc(1'b1, tbl[i].kl, tbl[i].ki, tbl[i].sv, tbl[i].sd);
      chk($sformatf("fips_ready[%0d]", i), {126'd0, s_ready, key_ready}, {126'd0, tbl[i].eRdy, tbl[i].eKrdy});
      chk($sformatf("fips_issue[%0d]", i), {127'd0, blk_issue}, {127'd0, tbl[i].eIss});
      chk($sformatf("fips_ct[%0d]", i), {127'd0, ct_valid}, {127'd0, tbl[i].eCt});
      chk($sformatf("fips_cnt[%0d]", i), {112'd0, blk_cnt}, {112'd0, tbl[i].eCnt});
      if (tbl[i].chkData) begin
        chk("fips_text", usrText, tbl[i].eText);
        chk("fips_key", Key, tbl[i].eKey);
      end
    end

    // No key loaded: words must be refused
    doReset();
    for (int c = 0; c < 8; c++) begin
      cyc(1'b1, 1'b0, '0, 1'b1, 32'h0bad_0000 + 32'(c));
      chk($sformatf("nokey_ready[%0d]", c), {127'd0, s_ready}, '0);
      chk($sformatf("nokey_issue[%0d]", c), {127'd0, blk_issue}, '0);
    end
    chk("nokey_cnt", {112'd0, blk_cnt}, '0);

    // Back-to-back: three blocks with s_valid held high
    doReset();
    for (int c = 0; c <= 30; c++) begin
      cyc(1'b1, (c == 0), K1, (c >= 1 && c <= 14), 32'h1000_0000 + 32'(c));
      chk($sformatf("b2b_ready[%0d]", c), {127'd0, s_ready},
          {127'd0, (c >= 1) && !(c == 5 || c == 10 || c == 15)});
      chk($sformatf("b2b_issue[%0d]", c), {127'd0, blk_issue},
          {127'd0, (c == 5 || c == 10 || c == 15)});
      chk($sformatf("b2b_ct[%0d]", c), {127'd0, ct_valid},
          {127'd0, (c == 17 || c == 22 || c == 27)});
      if (c == 15)
        chk("b2b_text3", usrText, {bsw(32'h1000_000b), bsw(32'h1000_000c),
                                   bsw(32'h1000_000d), bsw(32'h1000_000e)});
    end
    chk("b2b_cnt", {112'd0, blk_cnt}, 128'd3);

    // Key load colliding with a word after two accepts, then reset mid-flight
    doReset();
    cyc(1'b1, 1'b1, K1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0, 1'b1, 32'haaaa_0001);
    cyc(1'b1, 1'b0, '0, 1'b1, 32'haaaa_0002);
    cyc(1'b1, 1'b1, K2, 1'b1, 32'hffff_ffff);
    chk("klc_ready", {126'd0, s_ready, key_ready}, 128'b01);
    for (int c = 0; c < 4; c++) begin
      cyc(1'b1, 1'b0, '0, 1'b1, 32'hc0de_0000 + 32'(c));
      if (c == 0) chk("klc_newkey", Key, K2);
      chk($sformatf("klc_issue_early[%0d]", c), {127'd0, blk_issue}, '0);
    end
    cyc(1'b1, 1'b0, '0, 1'b0, '0);
    chk("klc_issue", {127'd0, blk_issue}, 128'd1);
    chk("klc_text", usrText, {bsw(32'hc0de_0000), bsw(32'hc0de_0001),
                              bsw(32'hc0de_0002), bsw(32'hc0de_0003)});
    chk("klc_key", Key, K2);
    cyc(1'b1, 1'b0, '0, 1'b0, '0);
    chk("klc_cnt", {112'd0, blk_cnt}, 128'd1);
    cyc(1'b1, 1'b0, '0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0, 1'b0, '0);
    cyc(1'b1, 1'b0, '0, 1'b1, 32'h1234_5678);
    chk("mrst_text", usrText, '0);
    chk("mrst_key", Key, '0);
    chk("mrst_cnt", {112'd0, blk_cnt}, '0);
    chk("mrst_flags", {124'd0, blk_issue, ct_valid, s_ready, key_ready}, 128'b0001);
    for (int c = 0; c < 14; c++) begin
      cyc(1'b1, 1'b0, '0, 1'b0, '0);
      chk($sformatf("mrst_ct[%0d]", c), {127'd0, ct_valid}, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
